// File: rtl/modn_preset_counter_pkg.sv
// ============================================================================
// Module  : modn_preset_counter_pkg
// Brief   : Shared constants and elaboration helpers for the modulo-N counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package modn_preset_counter_pkg;

    localparam int MOD_A_DEF = 7;
    localparam int MOD_B_DEF = 15;

    // Smallest bit width able to hold the values 0 .. n-1 (never less than 1).
    function automatic int clog2_min(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/modn_preset_counter_step.sv
// ============================================================================
// Module  : modn_step
// Brief   : Combinational up/down step with modulo wrap for the preset counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module modn_step
    import modn_preset_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_m_last,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap
);

    always_comb begin
        o_next = i_count;
        o_wrap = 1'b0;
        if (i_up) begin
            // An out-of-range value (above m_last) restarts at zero without a wrap.
            o_wrap = (i_count == i_m_last);
            if (i_count >= i_m_last) begin
                o_next = '0;
            end else begin
                o_next = i_count + 1'b1;
            end
        end else begin
            o_wrap = (i_count == '0);
            if ((i_count == '0) || (i_count > i_m_last)) begin
                o_next = i_m_last;
            end else begin
                o_next = i_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/modn_preset_counter.sv
// ============================================================================
// Module  : modn_preset_counter
// Brief   : Presettable up/down modulo-N counter with run-time modulus select,
//           cascade terminal count and load range error pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module modn_preset_counter
    import modn_preset_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD_A = MOD_A_DEF,
    parameter int MOD_B = MOD_B_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             load_err
);

    localparam int MOD_MAX = (MOD_A > MOD_B) ? MOD_A : MOD_B;

    generate
        if ((MOD_A < 2) || (MOD_A > (1 << WIDTH)) ||
            (MOD_B < 2) || (MOD_B > (1 << WIDTH)) ||
            (WIDTH < clog2_min(MOD_MAX))) begin : g_bad_param
            $error("modn_preset_counter: illegal WIDTH/MOD_A/MOD_B combination");
        end
    endgenerate

    // Terminal values fixed at elaboration; only a mux remains at run time.
    localparam logic [WIDTH-1:0] c_a_last = WIDTH'(MOD_A - 1);
    localparam logic [WIDTH-1:0] c_b_last = WIDTH'(MOD_B - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             load_err_q;
    logic             load_err_d;
    logic [WIDTH-1:0] w_m_last;
    logic [WIDTH-1:0] w_step_next;
    logic             w_step_wrap;

    assign w_m_last = mode ? c_b_last : c_a_last;

    modn_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_count  (count_q),
        .i_up     (up),
        .i_m_last (w_m_last),
        .o_next   (w_step_next),
        .o_wrap   (w_step_wrap)
    );

    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (load) begin
            if (load_val <= w_m_last) begin
                count_d = load_val;
            end else begin
                count_d    = '0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            count_d = w_step_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    // Not gated by load so a downstream stage sees the carry with zero latency.
    assign tc       = en & w_step_wrap;
    assign count    = count_q;
    assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_modn_preset_counter.sv
// ============================================================================
// Module  : tb_modn_preset_counter
// Brief   : Scoreboard bench for modn_preset_counter with a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modn_preset_counter;

    localparam int WIDTH = 4;
    localparam int MOD_A = 7;
    localparam int MOD_B = 15;

    typedef struct {
        int tc;
        int cnt;
        int err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             up = 1'b0;
    logic             mode = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             load_err;

    logic             c_rst = 1'b1;
    logic             c_en = 1'b0;
    logic [WIDTH-1:0] c0_count;
    logic [WIDTH-1:0] c1_count;
    logic             c0_tc;
    logic             c1_tc;
    logic             c0_err;
    logic             c1_err;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   m_cnt = 0;
    int   m_err = 0;

    always #5 clk = ~clk;

    modn_preset_counter #(.WIDTH(WIDTH), .MOD_A(MOD_A), .MOD_B(MOD_B)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .load_err(load_err)
    );

    modn_preset_counter #(.WIDTH(WIDTH), .MOD_A(MOD_A), .MOD_B(MOD_B)) u_s0 (
        .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .mode(1'b0), .load(1'b0),
        .load_val(4'd0), .count(c0_count), .tc(c0_tc), .load_err(c0_err)
    );

    modn_preset_counter #(.WIDTH(WIDTH), .MOD_A(MOD_A), .MOD_B(MOD_B)) u_s1 (
        .clk(clk), .rst(c_rst), .en(c0_tc), .up(1'b1), .mode(1'b0), .load(1'b0),
        .load_val(4'd0), .count(c1_count), .tc(c1_tc), .load_err(c1_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: modular arithmetic on plain integers.
    task automatic step(input bit e, input bit u, input bit md, input bit ld, input int v);
        int   m;
        exp_t x;
        @(negedge clk);
        en       = e;
        up       = u;
        mode     = md;
        load     = ld;
        load_val = 4'(v);
        m    = md ? MOD_B : MOD_A;
        x.tc = (e && ((u && m_cnt == m - 1) || (!u && m_cnt == 0))) ? 1 : 0;
        m_err = 0;
        if (ld) begin
            if (v < m) begin
                m_cnt = v;
            end else begin
                m_cnt = 0;
                m_err = 1;
            end
        end else if (e) begin
            if (m_cnt >= m) m_cnt = u ? 0 : m - 1;
            else if (u)     m_cnt = (m_cnt + 1) % m;
            else            m_cnt = (m_cnt + m - 1) % m;
        end
        x.cnt = m_cnt;
        x.err = m_err;
        q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
    endtask

    // Asserted between edges; outputs must clear without a clock edge.
    task automatic mid_reset();
        drain();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_err", int'(load_err), 0);
        #1;
        rst   = 1'b0;
        m_cnt = 0;
        m_err = 0;
    endtask

    initial begin : monitor
        int   a_tc;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                a_tc = int'(tc);
                @(posedge clk);
                #1;
                e = q.pop_front();
                chk("tc", a_tc, e.tc);
                chk("count", int'(count), e.cnt);
                chk("load_err", int'(load_err), e.err);
            end
        end
    end

    initial begin : stim
        #2;
        chk("reset_count", int'(count), 0);
        chk("reset_err", int'(load_err), 0);
        chk("reset_tc", int'(tc), 0);
        #10;
        rst = 1'b0;

        // Count to 4, reset mid-cycle, then a full mod-7 up cycle.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        mid_reset();
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0);

        // Mode 1 up from 0 for 20 cycles.
        mid_reset();
        for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0);

        // Down count from a preset of 2 in mode 0.
        step(0, 0, 0, 1, 2);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);

        // Out-of-range preset in mode 0, same value legal in mode 1.
        step(0, 1, 0, 1, 9);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 9);
        step(0, 1, 1, 0, 0);

        // Mode 1 -> 0 switch leaving count out of range, up then down.
        step(0, 1, 1, 1, 12);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 12);
        step(1, 0, 0, 0, 0);

        // Load and enable together at the terminal count.
        step(0, 1, 0, 1, 6);
        step(1, 1, 0, 1, 3);
        step(1, 1, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                 $urandom_range(9, 0) == 0 ? ~mode : mode,
                 $urandom_range(9, 0) == 0, int'($urandom_range(15, 0)));
        end
        step(0, 0, mode, 0, 0);
        drain();

        // Cascade: stage 1 advances once per seven stage-0 clocks.
        @(negedge clk);
        c_rst = 1'b0;
        c_en  = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            chk("cascade_s0", int'(c0_count), n % 7);
            chk("cascade_s1", int'(c1_count), (n / 7) % 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
